// File: rtl/ps_mm_region_writer_if.sv
// Interface: stream-in / memory-write-out / status bundle for ps_mm_region_writer.
// Latency: none (wires only).
// Backpressure: i_rdy from the writer, m_busy from the memory side.
interface ps_mm_region_writer_if #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 16,
  parameter int SYMBOLS = 4,
  parameter int LWIDTH  = 16
);
  logic [AWIDTH-1:0]          cfg_base;
  logic [AWIDTH-1:0]          cfg_size;
  logic [DWIDTH-1:0]          i_dat;
  logic [$clog2(SYMBOLS)-1:0] i_mty;
  logic                       i_val;
  logic                       i_eop;
  logic                       i_rdy;
  logic [AWIDTH-1:0]          m_addr;
  logic [SYMBOLS-1:0]         m_bena;
  logic                       m_wreq;
  logic [DWIDTH-1:0]          m_wdat;
  logic                       m_busy;
  logic [LWIDTH-1:0]          st_len;
  logic [LWIDTH-1:0]          st_wr;
  logic                       st_ovf;
  logic                       st_val;

  // Writer side
  modport slave (
    input  cfg_base, cfg_size, i_dat, i_mty, i_val, i_eop, m_busy,
    output i_rdy, m_addr, m_bena, m_wreq, m_wdat, st_len, st_wr, st_ovf, st_val
  );

  // Environment side (packet source, memory port, status consumer)
  modport master (
    output cfg_base, cfg_size, i_dat, i_mty, i_val, i_eop, m_busy,
    input  i_rdy, m_addr, m_bena, m_wreq, m_wdat, st_len, st_wr, st_ovf, st_val
  );
endinterface

// File: rtl/ps_mm_region_writer.sv
// Purpose: write packet beats into region [base, base+size); truncate, or wrap to base when PS_MM_REGION_WRITER_WRAP_EN is defined.
// Latency: write request and per-packet status appear 1 cycle after beat acceptance.
// Backpressure: one-entry write register; i_rdy low only while a request is stalled by m_busy.
module ps_mm_region_writer #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 16,
  parameter int SYMBOLS = 4,
  parameter int LWIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ps_mm_region_writer_if.slave  bus
);

  typedef enum logic {ST_BODY = 1'b0, ST_SOP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic [AWIDTH-1:0]   size_q, size_d;
  logic [AWIDTH-1:0]   off_q, off_d;
  logic                full_q, full_d;   // offset has reached size at least once
  logic                ovf_q, ovf_d;
  logic [LWIDTH-1:0]   len_q, len_d;
  logic [LWIDTH-1:0]   wr_q, wr_d;

  logic                m_wreq_q, m_wreq_d;
  logic [AWIDTH-1:0]   m_addr_q, m_addr_d;
  logic [SYMBOLS-1:0]  m_bena_q, m_bena_d;
  logic [DWIDTH-1:0]   m_wdat_q, m_wdat_d;

  logic                st_val_q, st_val_d;
  logic [LWIDTH-1:0]   st_len_q, st_len_d;
  logic [LWIDTH-1:0]   st_wr_q, st_wr_d;
  logic                st_ovf_q, st_ovf_d;

  // Per-beat working values: SOP beats see fresh config and cleared counters
  logic                accept;
  logic                do_write;
  logic                cur_full, cur_ovf;
  logic [AWIDTH-1:0]   cur_base, cur_size, cur_off, off_inc;
  logic [LWIDTH-1:0]   cur_len, cur_wr;

  assign bus.i_rdy  = ~m_wreq_q | ~bus.m_busy;
  assign accept     = bus.i_val & bus.i_rdy;

  assign bus.m_wreq = m_wreq_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_bena = m_bena_q;
  assign bus.m_wdat = m_wdat_q;
  assign bus.st_val = st_val_q;
  assign bus.st_len = st_len_q;
  assign bus.st_wr  = st_wr_q;
  assign bus.st_ovf = st_ovf_q;

  // Next-state: packet tracking, write register load/drain, status strobe
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    size_d   = size_q;
    off_d    = off_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    len_d    = len_q;
    wr_d     = wr_q;
    m_wreq_d = m_wreq_q;
    m_addr_d = m_addr_q;
    m_bena_d = m_bena_q;
    m_wdat_d = m_wdat_q;
    st_val_d = 1'b0;
    st_len_d = st_len_q;
    st_wr_d  = st_wr_q;
    st_ovf_d = st_ovf_q;

    if (state_q == ST_SOP) begin
      cur_base = bus.cfg_base;
      cur_size = bus.cfg_size;
      cur_off  = '0;
      cur_full = 1'b0;
      cur_ovf  = 1'b0;
      cur_len  = '0;
      cur_wr   = '0;
    end else begin
      cur_base = base_q;
      cur_size = size_q;
      cur_off  = off_q;
      cur_full = full_q;
      cur_ovf  = ovf_q;
      cur_len  = len_q;
      cur_wr   = wr_q;
    end
    do_write = (cur_off < cur_size);
    off_inc  = cur_off + AWIDTH'(1);

    if (accept) begin
      state_d = bus.i_eop ? ST_SOP : ST_BODY;
      base_d  = cur_base;
      size_d  = cur_size;
      // A beat arriving once the region is used up (or empty) marks overflow
      ovf_d   = cur_ovf | cur_full | (cur_size == '0);
      len_d   = (cur_len == {LWIDTH{1'b1}}) ? cur_len : cur_len + LWIDTH'(1);

      if (do_write) begin
        full_d = cur_full | (off_inc == cur_size);
`ifdef PS_MM_REGION_WRITER_WRAP_EN
        off_d  = (off_inc == cur_size) ? '0 : off_inc;
`else
        off_d  = off_inc;
`endif
        wr_d     = (cur_wr == {LWIDTH{1'b1}}) ? cur_wr : cur_wr + LWIDTH'(1);
        m_addr_d = cur_base + cur_off;
        m_wdat_d = bus.i_dat;
        m_bena_d = bus.i_eop ? ({SYMBOLS{1'b1}} >> bus.i_mty) : {SYMBOLS{1'b1}};
      end else begin
        off_d  = cur_off;
        full_d = cur_full;
        wr_d   = cur_wr;
      end
      m_wreq_d = do_write;

      if (bus.i_eop) begin
        st_val_d = 1'b1;
        st_len_d = len_d;
        st_wr_d  = wr_d;
        st_ovf_d = ovf_d;
      end
    end else if (!bus.m_busy) begin
      m_wreq_d = 1'b0;
    end
  end

  // State registers with asynchronous reset; reset discards any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SOP;
      base_q   <= '0;
      size_q   <= '0;
      off_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      len_q    <= '0;
      wr_q     <= '0;
      m_wreq_q <= 1'b0;
      m_addr_q <= '0;
      m_bena_q <= '0;
      m_wdat_q <= '0;
      st_val_q <= 1'b0;
      st_len_q <= '0;
      st_wr_q  <= '0;
      st_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      size_q   <= size_d;
      off_q    <= off_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      m_wreq_q <= m_wreq_d;
      m_addr_q <= m_addr_d;
      m_bena_q <= m_bena_d;
      m_wdat_q <= m_wdat_d;
      st_val_q <= st_val_d;
      st_len_q <= st_len_d;
      st_wr_q  <= st_wr_d;
      st_ovf_q <= st_ovf_d;
    end
  end

endmodule

// File: tb/tb_ps_mm_region_writer.sv
// Bench for ps_mm_region_writer: directed packets, expected writes/status queued at issue time.
// Monitor pops and compares on every completed write (m_wreq & ~m_busy) and every status strobe.
// Stall behaviour checked by holding m_busy and comparing held outputs cycle to cycle.
`timescale 1ns/1ps
module tb_ps_mm_region_writer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SY = 4;
  localparam int LW = 4;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps_mm_region_writer_if #(.DWIDTH(DW), .AWIDTH(AW), .SYMBOLS(SY), .LWIDTH(LW)) bus ();

  ps_mm_region_writer #(.DWIDTH(DW), .AWIDTH(AW), .SYMBOLS(SY), .LWIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SY-1:0] bena;
    logic [DW-1:0] dat;
  } wr_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [LW-1:0] wr;
    logic          ovf;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks = 0;
  int  errors = 0;
  int  st_seen = 0;
  int  st_exp = 0;
  int  stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [SY-1:0] b, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a; e.bena = b; e.dat = d;
    wq.push_back(e);
  endtask

  task automatic push_st(input logic [LW-1:0] l, input logic [LW-1:0] w, input logic o);
    st_t s;
    s.len = l; s.wr = w; s.ovf = o;
    sq.push_back(s);
    st_exp++;
  endtask

  // Hold one beat on the input until accepted (bounded)
  task automatic send_beat(input logic [DW-1:0] d, input logic eop, input logic [MW-1:0] mty);
    bit acc;
    acc = 1'b0;
    bus.i_val = 1'b1;
    bus.i_dat = d;
    bus.i_eop = eop;
    bus.i_mty = mty;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.i_rdy;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0h not accepted, required acceptance within 50 cycles", d);
    end
    bus.i_val = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_mty = '0;
  endtask

  task automatic send_pkt(input int n, input logic [DW-1:0] tag, input logic [MW-1:0] mty);
    for (int i = 0; i < n; i++)
      send_beat(tag + DW'(i), (i == n - 1), (i == n - 1) ? mty : MW'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: completed writes, stall holding, status strobes
  logic prev_stall;
  wr_t  prev, got_w, exp_w;
  st_t  exp_s;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_wreq", bus.m_wreq, 1);
        chk("hold_addr", bus.m_addr, prev.addr);
        chk("hold_bena", bus.m_bena, prev.bena);
        chk("hold_wdat", bus.m_wdat, prev.dat);
      end
      if (bus.m_wreq && bus.m_busy) begin
        stall_cnt++;
        chk("rdy_stall", bus.i_rdy, 0);
      end
      if (bus.m_wreq && !bus.m_busy) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, required no write", bus.m_addr, bus.m_wdat);
        end else begin
          exp_w = wq.pop_front();
          chk("wr_addr", bus.m_addr, exp_w.addr);
          chk("wr_bena", bus.m_bena, exp_w.bena);
          chk("wr_wdat", bus.m_wdat, exp_w.dat);
        end
      end
      if (bus.st_val) begin
        st_seen++;
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_status: len %0d wr %0d ovf %0d, required no strobe",
                   bus.st_len, bus.st_wr, bus.st_ovf);
        end else begin
          exp_s = sq.pop_front();
          chk("st_len", bus.st_len, exp_s.len);
          chk("st_wr", bus.st_wr, exp_s.wr);
          chk("st_ovf", bus.st_ovf, exp_s.ovf);
        end
      end
      prev_stall = bus.m_wreq && bus.m_busy;
      got_w.addr = bus.m_addr;
      got_w.bena = bus.m_bena;
      got_w.dat  = bus.m_wdat;
      prev = got_w;
    end
  end

  initial begin
    reset = 1'b1;
    bus.i_val = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_mty = '0;
    bus.i_dat = '0;
    bus.m_busy = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_size = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #3;
    chk("rst_wreq", bus.m_wreq, 0);
    chk("rst_addr", bus.m_addr, 0);
    chk("rst_bena", bus.m_bena, 0);
    chk("rst_wdat", bus.m_wdat, 0);
    chk("rst_stval", bus.st_val, 0);
    chk("rst_stlen", bus.st_len, 0);
    chk("rst_stwr", bus.st_wr, 0);
    chk("rst_stovf", bus.st_ovf, 0);
    chk("rst_rdy", bus.i_rdy, 1);
    reset = 1'b0;
    idle(2);

    // 1: basic 3-beat packet, mty=1 on EOP
    bus.cfg_base = 8'h10; bus.cfg_size = 8'd8;
    push_wr(8'h10, 4'b1111, 32'h1000_0000);
    push_wr(8'h11, 4'b1111, 32'h1000_0001);
    push_wr(8'h12, 4'b0111, 32'h1000_0002);
    push_st(4'd3, 4'd3, 1'b0);
    send_pkt(3, 32'h1000_0000, 2'd1);
    idle(3);

    // 2: m_busy high for 3 cycles mid-packet
    bus.cfg_base = 8'h20; bus.cfg_size = 8'd8;
    for (int i = 0; i < 4; i++) push_wr(AW'(8'h20 + i), 4'b1111, 32'h2000_0000 + DW'(i));
    push_st(4'd4, 4'd4, 1'b0);
    stall_cnt = 0;
    fork
      send_pkt(4, 32'h2000_0000, 2'd0);
      begin
        repeat (2) @(posedge clk);
        #1 bus.m_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.m_busy = 1'b0;
      end
    join
    idle(3);
    chk("stall_cycles", stall_cnt, 3);

    // 3: overlong packet, size=4, 6 beats
    bus.cfg_base = 8'h10; bus.cfg_size = 8'd4;
    for (int i = 0; i < 4; i++) push_wr(AW'(8'h10 + i), 4'b1111, 32'h3000_0000 + DW'(i));
`ifdef PS_MM_REGION_WRITER_WRAP_EN
    push_wr(8'h10, 4'b1111, 32'h3000_0004);
    push_wr(8'h11, 4'b1111, 32'h3000_0005);
    push_st(4'd6, 4'd6, 1'b1);
`else
    push_st(4'd6, 4'd4, 1'b1);
`endif
    send_pkt(6, 32'h3000_0000, 2'd0);
    idle(3);

    // 4: address wraps modulo 2^AWIDTH, exact fit -> no overflow; mty=2
    bus.cfg_base = 8'hFE; bus.cfg_size = 8'd4;
    push_wr(8'hFE, 4'b1111, 32'h4000_0000);
    push_wr(8'hFF, 4'b1111, 32'h4000_0001);
    push_wr(8'h00, 4'b1111, 32'h4000_0002);
    push_wr(8'h01, 4'b0011, 32'h4000_0003);
    push_st(4'd4, 4'd4, 1'b0);
    send_pkt(4, 32'h4000_0000, 2'd2);
    idle(3);

    // Empty region: every beat dropped, overflow flagged
    bus.cfg_base = 8'h30; bus.cfg_size = 8'd0;
    push_st(4'd2, 4'd0, 1'b1);
    send_pkt(2, 32'h4800_0000, 2'd0);
    idle(3);

    // 5: back-to-back packets, cfg_base changed during packet 1
    bus.cfg_base = 8'h10; bus.cfg_size = 8'd8;
    push_wr(8'h10, 4'b1111, 32'h5000_0000);
    push_wr(8'h11, 4'b1111, 32'h5000_0001);
    push_wr(8'h12, 4'b1111, 32'h5000_0002);
    push_st(4'd3, 4'd3, 1'b0);
    push_wr(8'h40, 4'b1111, 32'h5100_0000);
    push_wr(8'h41, 4'b1111, 32'h5100_0001);
    push_st(4'd2, 4'd2, 1'b0);
    fork
      send_pkt(3, 32'h5000_0000, 2'd0);
      begin
        @(posedge clk);
        #2 bus.cfg_base = 8'h40;
      end
    join
    send_pkt(2, 32'h5100_0000, 2'd0);
    idle(3);

    // Counter saturation (LWIDTH=4): 17 beats into an 8-word region
    bus.cfg_base = 8'h60; bus.cfg_size = 8'd8;
`ifdef PS_MM_REGION_WRITER_WRAP_EN
    for (int i = 0; i < 17; i++) push_wr(AW'(8'h60 + (i % 8)), 4'b1111, 32'h6000_0000 + DW'(i));
    push_st(4'd15, 4'd15, 1'b1);
`else
    for (int i = 0; i < 8; i++) push_wr(AW'(8'h60 + i), 4'b1111, 32'h6000_0000 + DW'(i));
    push_st(4'd15, 4'd8, 1'b1);
`endif
    send_pkt(17, 32'h6000_0000, 2'd0);
    idle(3);

    // 6: reset mid-packet with a stalled write pending
    bus.cfg_base = 8'h70; bus.cfg_size = 8'd8;
    bus.m_busy = 1'b1;
    send_beat(32'h7000_0000, 1'b0, 2'd0);
    chk("pre_rst_wreq", bus.m_wreq, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wreq", bus.m_wreq, 0);
    chk("mid_rst_rdy", bus.i_rdy, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    bus.m_busy = 1'b0;
    bus.cfg_base = 8'h50;
    idle(1);
    push_wr(8'h50, 4'b1111, 32'h7100_0000);
    push_st(4'd1, 4'd1, 1'b0);
    send_beat(32'h7100_0000, 1'b1, 2'd0);
    idle(3);

    // Drain and final accounting
    for (int n = 0; n < 200 && (wq.size() != 0 || sq.size() != 0); n++) @(posedge clk);
    chk("drain_writes", wq.size(), 0);
    chk("drain_status", sq.size(), 0);
    chk("status_count", st_seen, st_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
